// File: rtl/mad_min_select.sv
// Minimum-SAD selector: scans NUM_CAND candidate words per search and reports
// the smallest SAD with its motion-vector address, earliest candidate winning ties.
module mad_min_select #(
    parameter int NUM_CAND = 64,
    parameter int SAD_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mad_valid,
    input  logic [SAD_W+8:0] mad_res,
    output logic             busy,
    output logic             done,
    output logic [SAD_W+8:0] compare_out,
    output logic [3:0]       mv_y,
    output logic [3:0]       mv_x,
    output logic [7:0]       cand_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int             CW   = $clog2(NUM_CAND + 1);
    localparam logic [CW-1:0]  LAST = CW'(NUM_CAND - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [SAD_W-1:0] run_min;
    logic [7:0]       run_addr;
    logic [CW-1:0]    cnt;
    logic [SAD_W+8:0] result;

    logic [SAD_W-1:0] cand_sad;
    logic [7:0]       cand_addr;
    logic             accept;
    logic             take;
    logic             last;
    logic [SAD_W-1:0] nxt_min;
    logic [7:0]       nxt_addr;
    logic [8:0]       cnt_wide;
    logic             unused_flag;

    assign cand_sad    = mad_res[SAD_W+7:8];
    assign cand_addr   = mad_res[7:0];
    assign unused_flag = mad_res[SAD_W+8];

    // A start pulse always wins, so a candidate arriving with it is dropped.
    assign accept = (state == SEARCH) && mad_valid && !start;
    // The first candidate is forced in so an all-ones SAD still records its address.
    assign take   = accept && ((cnt == '0) || (cand_sad < run_min));
    assign last   = accept && (cnt == LAST);

    assign nxt_min  = take ? cand_sad  : run_min;
    assign nxt_addr = take ? cand_addr : run_addr;

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = SEARCH;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                SEARCH:  next_state = last ? DONE : SEARCH;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_min  <= '1;
            run_addr <= '0;
            cnt      <= '0;
            result   <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                run_min  <= '1;
                run_addr <= '0;
                cnt      <= '0;
            end else if (accept) begin
                run_min  <= nxt_min;
                run_addr <= nxt_addr;
                cnt      <= cnt + 1'b1;
                if (last) begin
                    result <= {1'b0, nxt_min, nxt_addr};
                end
            end
        end
    end

    // The 8-bit count port cannot show 256, so it pins at 255 in that corner.
    assign cnt_wide = 9'(cnt);
    assign cand_cnt = cnt_wide[8] ? 8'hFF : cnt_wide[7:0];

    assign busy        = (state == SEARCH);
    assign done        = (state == DONE);
    assign compare_out = result;
    assign mv_y        = result[7:4];
    assign mv_x        = result[3:0];

endmodule

// File: tb/tb_mad_min_select.sv
// Directed bench for mad_min_select with NUM_CAND=4: table of full searches plus
// hand-written sequences for gaps, abort, restart from DONE and mid-search reset.
module tb_mad_min_select;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mad_valid = 1'b0;
    logic [20:0] mad_res = '0;
    logic        busy;
    logic        done;
    logic [20:0] compare_out;
    logic [3:0]  mv_y;
    logic [3:0]  mv_x;
    logic [7:0]  cand_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        string          name;
        logic [3:0][11:0] sad;
        logic [3:0][7:0]  addr;
        logic [11:0]    exp_sad;
        logic [7:0]     exp_addr;
    } vec_t;

    vec_t vecs[6];

    mad_min_select #(.NUM_CAND(NC), .SAD_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mad_valid   (mad_valid),
        .mad_res     (mad_res),
        .busy        (busy),
        .done        (done),
        .compare_out (compare_out),
        .mv_y        (mv_y),
        .mv_x        (mv_x),
        .cand_cnt    (cand_cnt)
    );

    always #5 clk = ~clk;

    // Done pulses are tallied mid-cycle so aborted or reset searches can be audited.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [11:0] s, input logic [7:0] a);
        mad_valid = 1'b1;
        mad_res   = {1'b0, s, a};
        tick();
        mad_valid = 1'b0;
        mad_res   = '0;
    endtask

    task automatic check_result(input string name, input logic [11:0] s, input logic [7:0] a);
        checkOutput({name, " done"}, 32'(done), 32'd1);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " compare_out"}, 32'(compare_out), 32'({1'b0, s, a}));
        checkOutput({name, " mv_y"}, 32'(mv_y), 32'(a[7:4]));
        checkOutput({name, " mv_x"}, 32'(mv_x), 32'(a[3:0]));
        checkOutput({name, " cand_cnt"}, 32'(cand_cnt), 32'(NC));
    endtask

    task automatic applyStimulus(input vec_t v);
        int d0;
        d0 = done_cnt;
        pulse_start();
        checkOutput({v.name, " busy_after_start"}, 32'(busy), 32'd1);
        checkOutput({v.name, " cnt_after_start"}, 32'(cand_cnt), 32'd0);
        for (int i = 0; i < NC; i++) begin
            mad_valid = 1'b1;
            // Bit 20 toggles to show it never leaks into the result.
            mad_res   = {1'(i), v.sad[i], v.addr[i]};
            tick();
            if (i == 1) begin
                checkOutput({v.name, " cnt_mid"}, 32'(cand_cnt), 32'd2);
                checkOutput({v.name, " done_mid"}, 32'(done), 32'd0);
            end
        end
        mad_valid = 1'b0;
        mad_res   = '0;
        check_result(v.name, v.exp_sad, v.exp_addr);
        tick();
        checkOutput({v.name, " done_low"}, 32'(done), 32'd0);
        checkOutput({v.name, " cnt_hold"}, 32'(cand_cnt), 32'(NC));
        checkOutput({v.name, " result_hold"}, 32'(compare_out), 32'({1'b0, v.exp_sad, v.exp_addr}));
        checkOutput({v.name, " one_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        int gaps[3];

        vecs[0] = '{"basic",   {12'd200, 12'd450, 12'd120, 12'd300}, {8'h3E, 8'h3D, 8'h3C, 8'h3B}, 12'd120, 8'h3C};
        vecs[1] = '{"tie",     {12'd90,  12'd70,  12'd50,  12'd50},  {8'h14, 8'h13, 8'h12, 8'h11}, 12'd50,  8'h11};
        vecs[2] = '{"allmax",  {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, {8'h23, 8'h22, 8'h21, 8'h20}, 12'hFFF, 8'h20};
        vecs[3] = '{"desc",    {12'd100, 12'd200, 12'd300, 12'd400}, {8'h04, 8'h03, 8'h02, 8'h01}, 12'd100, 8'h04};
        vecs[4] = '{"nearmax", {12'hFFE, 12'hFFF, 12'hFFE, 12'hFFF}, {8'h53, 8'h52, 8'h51, 8'h50}, 12'hFFE, 8'h51};
        vecs[5] = '{"zeros",   {12'd0,   12'd5,   12'd0,   12'd0},   {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 12'd0,   8'hAA};

        // Reset state, with valid traffic while held in reset
        mad_valid = 1'b1;
        mad_res   = {1'b0, 12'd7, 8'h99};
        tick();
        tick();
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst compare_out", 32'(compare_out), 32'd0);
        checkOutput("rst mv", 32'({mv_y, mv_x}), 32'd0);
        checkOutput("rst cand_cnt", 32'(cand_cnt), 32'd0);
        rst_n = 1'b1;

        // Valid while idle is ignored
        tick();
        tick();
        mad_valid = 1'b0;
        mad_res   = '0;
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle cand_cnt", 32'(cand_cnt), 32'd0);
        checkOutput("idle done_cnt", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Gapped candidates: busy holds through the idle cycles
        gaps = '{2, 1, 2};
        pulse_start();
        for (int i = 0; i < NC; i++) begin
            case (i)
                0: send(12'd900, 8'h41);
                1: send(12'd700, 8'h42);
                2: send(12'd800, 8'h43);
                default: send(12'd701, 8'h44);
            endcase
            if (i < NC - 1) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    tick();
                    checkOutput("gap busy", 32'(busy), 32'd1);
                    checkOutput("gap done", 32'(done), 32'd0);
                end
            end
        end
        check_result("gapped", 12'd700, 8'h42);
        tick();

        // Abort mid-search; candidate alongside the restart pulse is discarded
        d0 = done_cnt;
        pulse_start();
        send(12'd5, 8'h01);
        send(12'd3, 8'h02);
        mad_valid = 1'b1;
        mad_res   = {1'b0, 12'd1, 8'h77};
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mad_valid = 1'b0;
        checkOutput("abort cnt_restart", 32'(cand_cnt), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd1);
        send(12'd40, 8'hA1);
        send(12'd10, 8'hA5);
        send(12'd20, 8'hA6);
        send(12'd10, 8'hA7);
        check_result("abort", 12'd10, 8'hA5);
        tick();
        checkOutput("abort one_done", 32'(done_cnt - d0), 32'd1);

        // Start during DONE: done still pulses, old result holds through next search
        pulse_start();
        send(12'd100, 8'h10);
        send(12'd90,  8'h11);
        send(12'd95,  8'h12);
        send(12'd80,  8'h13);
        start = 1'b1;
        check_result("restart_first", 12'd80, 8'h13);
        tick();
        start = 1'b0;
        checkOutput("restart busy", 32'(busy), 32'd1);
        checkOutput("restart cnt", 32'(cand_cnt), 32'd0);
        send(12'd60, 8'h21);
        send(12'd70, 8'h22);
        checkOutput("restart result_held", 32'(compare_out), 32'({1'b0, 12'd80, 8'h13}));
        send(12'd61, 8'h23);
        send(12'd62, 8'h24);
        check_result("restart_second", 12'd60, 8'h21);
        tick();

        // Reset after three of four candidates, then valid without start
        d0 = done_cnt;
        pulse_start();
        send(12'd30, 8'h31);
        send(12'd20, 8'h32);
        send(12'd25, 8'h33);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst compare_out", 32'(compare_out), 32'd0);
        checkOutput("midrst cand_cnt", 32'(cand_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) send(12'd1, 8'(i));
        tick();
        checkOutput("postrst busy", 32'(busy), 32'd0);
        checkOutput("postrst cand_cnt", 32'(cand_cnt), 32'd0);
        checkOutput("postrst compare_out", 32'(compare_out), 32'd0);
        checkOutput("postrst no_done", 32'(done_cnt - d0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
